shared_adder_scheduler: RTL
===========================

# shared_adder_scheduler

Sequential, single-adder replacement for the two-adder operand-select/add stage: accepts X and Y add requests over valid/ready, selects each request's operand pair at acceptance, and time-multiplexes one WIDTH-bit adder between the two channels with round-robin arbitration. Sits directly downstream of the operand sources and feeds the x/y result consumers. Trades one adder for one to two cycles of latency.

## Interface
- WIDTH, 8, operand width; results are WIDTH+1 bits.
- CNT_W, 16, width of the completed-operation counter.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- a, b, c, d, e, f  in  WIDTH each  operand buses, sampled only at request acceptance.
- x_req_valid  in  1; x_req_ready  out  1; x_sel  in  1  (1: a+b, 0: c+d).
- y_req_valid  in  1; y_req_ready  out  1; y_sel  in  1  (1: e+f, 0: a+b).
- x_res  out  WIDTH+1; x_res_valid  out  1; x_res_ready  in  1.
- y_res  out  WIDTH+1; y_res_valid  out  1; y_res_ready  in  1.
- op_count  out  CNT_W  completed additions, wraps modulo 2^CNT_W.

## Operation
- Per channel state: pend flag, captured operand pair (op0, op1), result register, res_valid flag.
- req_ready = !pend && !res_valid (combinational from registers only, never from inputs).
- Accept (valid && ready at edge): op0/op1 <= selected pair per *_sel; pend <= 1.
- Arbiter, every cycle, among channels with pend=1: one pending, grant it; both pending, grant channel named by rr pointer (reset = X), then rr <= other channel. rr changes only on a contested grant.
- Grant: res <= op0 + op1 at full WIDTH+1 (carry kept, no overflow); res_valid <= 1; pend <= 0; op_count <= op_count + 1.
- Consume: res_valid && res_ready at edge -> res_valid <= 0; res holds its last value.
- Channels independent apart from the shared adder; a stalled consumer on one channel never blocks the other.
- Reset (any cycle, including with operations pending): pend, res_valid, res, op0/op1, op_count all 0; rr = X; in-flight requests discarded.

## Timing
- All outputs registered or decoded from registers; reset values: req_ready 1 (after first rst_n=1 edge, 0 while rst_n=0), res 0, res_valid 0, op_count 0.
- Uncontested latency: accept at edge N, res_valid high after edge N+1.
- Contested (both accepted same edge): winner at N+1, loser at N+2.
- Per-channel throughput with res_ready held high: accept N, result N+1, consume N+2, req_ready high after N+2, next accept N+3.
- Operand changes after acceptance have no effect on the result.
- Simultaneous accept on one channel and grant on the other in the same edge is legal; both take effect.

## Structure
- Package shared_adder_pkg: WIDTH/CNT_W defaults, channel enum {CH_X, CH_Y} for rr and grant.
- Sub-module operand_select: 2:1 mux of operand pairs, instantiated once per channel.
- One adder instance only; synthesis must show a single WIDTH-bit adder.

## Test plan
- Reset: rst_n=0 for 2 edges with x/y_req_valid high -> no accepts, res_valid 0, op_count 0, req_ready 1 after release.
- X only: x_sel=1, a=200, b=100, accepted edge N -> x_res=300 (9-bit), x_res_valid after N+1, op_count=1.
- Contention: x_sel=0 (c=5,d=7), y_sel=1 (e=255,f=255) accepted same edge -> x_res=12 at N+1, y_res=510 at N+2; repeat -> Y wins first.
- Back-pressure: y_res_ready=0 for 10 cycles -> y_res_valid/y_res held, y_req_ready 0, X channel completes 3 ops meanwhile.
- Operand change after accept: y_sel=0, a=1,b=2 accepted, a changed to 50 next cycle -> y_res=3.
- Reset mid-operation: both pending, rst_n=0 one edge -> no result produced, all flags 0, rr=X; op_count wraps from 2^CNT_W-1 to 0 in a preloaded run.

Source files
------------

// File: rtl/shared_adder_scheduler_pkg.sv
// Package for the shared-adder scheduler: default widths, the channel
// enumeration used by the round-robin pointer and the grant decode, and
// a helper that names the opposite channel.
package shared_adder_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        CH_X = 1'b0,
        CH_Y = 1'b1
    } channel_t;

    // Opposite channel, used to hand priority over after a contested grant.
    function automatic channel_t other_ch(input channel_t ch);
        channel_t res;
        case (ch)
            CH_X:    res = CH_Y;
            CH_Y:    res = CH_X;
            default: res = CH_X;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shared_adder_scheduler_if.sv
// Bus between the operand sources / result consumers and the scheduler.
// Carries the six operand buses, the X and Y request handshakes with their
// pair selects, the X and Y result handshakes, and the completed-operation
// counter. The scheduler uses the slave modport; the environment uses master.
interface shared_adder_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a, b, c, d, e, f;
    logic             x_req_valid, x_req_ready, x_sel;
    logic             y_req_valid, y_req_ready, y_sel;
    logic [WIDTH:0]   x_res, y_res;
    logic             x_res_valid, x_res_ready;
    logic             y_res_valid, y_res_ready;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  a, b, c, d, e, f,
        input  x_req_valid, x_sel, y_req_valid, y_sel,
        input  x_res_ready, y_res_ready,
        output x_req_ready, y_req_ready,
        output x_res, x_res_valid, y_res, y_res_valid,
        output op_count
    );

    modport master (
        output a, b, c, d, e, f,
        output x_req_valid, x_sel, y_req_valid, y_sel,
        output x_res_ready, y_res_ready,
        input  x_req_ready, y_req_ready,
        input  x_res, x_res_valid, y_res, y_res_valid,
        input  op_count
    );
endinterface

// File: rtl/shared_adder_scheduler_operand_select.sv
// 2:1 selector of operand pairs. sel=1 passes (p0,p1), sel=0 passes (q0,q1).
// Ports: sel, p0/p1, q0/q1 in; op0/op1 out (WIDTH bits each).
module operand_select #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] p0,
    input  logic [WIDTH-1:0] p1,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] op0,
    output logic [WIDTH-1:0] op1
);

    // Pair multiplexer.
    always_comb begin
        op0 = q0;
        op1 = q1;
        if (sel) begin
            op0 = p0;
            op1 = p1;
        end else begin
            op0 = q0;
            op1 = q1;
        end
    end

endmodule

// File: rtl/shared_adder_scheduler.sv
// Shared-adder scheduler: accepts X and Y add requests, captures each
// request's operand pair at acceptance and time-multiplexes a single adder
// between the two channels with round-robin arbitration on contention.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport) carrying
// operands, request/result handshakes and the op_count counter.
module shared_adder_scheduler
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shared_adder_scheduler_if.slave bus
);

    logic [WIDTH-1:0] x_sel0_s, x_sel1_s, y_sel0_s, y_sel1_s;
    logic [WIDTH-1:0] x_op0_r, x_op1_r, y_op0_r, y_op1_r;
    logic [WIDTH-1:0] add_a_s, add_b_s;
    logic [WIDTH:0]   sum_s, x_res_r, y_res_r;
    logic             x_pend_r, y_pend_r, x_res_valid_r, y_res_valid_r;
    logic             ready_en_r, x_ready_s, y_ready_s, x_accept_s, y_accept_s;
    logic             grant_any_s;
    channel_t         grant_ch_s, rr_r, rr_next_s;
    logic [CNT_W-1:0] op_count_r;

    operand_select #(.WIDTH(WIDTH)) u_x_select (
        .sel(bus.x_sel), .p0(bus.a), .p1(bus.b), .q0(bus.c), .q1(bus.d),
        .op0(x_sel0_s), .op1(x_sel1_s)
    );

    operand_select #(.WIDTH(WIDTH)) u_y_select (
        .sel(bus.y_sel), .p0(bus.e), .p1(bus.f), .q0(bus.a), .q1(bus.b),
        .op0(y_sel0_s), .op1(y_sel1_s)
    );

    // ready_en_r keeps req_ready low while reset is asserted and for the reset edge itself.
    assign x_ready_s  = ready_en_r && !x_pend_r && !x_res_valid_r;
    assign y_ready_s  = ready_en_r && !y_pend_r && !y_res_valid_r;
    assign x_accept_s = bus.x_req_valid && x_ready_s;
    assign y_accept_s = bus.y_req_valid && y_ready_s;

    // Arbitration, operand steering into the single adder, and next rr pointer.
    always_comb begin
        grant_any_s = 1'b0;
        grant_ch_s  = CH_X;
        rr_next_s   = rr_r;
        case ({x_pend_r, y_pend_r})
            2'b10: begin
                grant_any_s = 1'b1;
                grant_ch_s  = CH_X;
            end
            2'b01: begin
                grant_any_s = 1'b1;
                grant_ch_s  = CH_Y;
            end
            2'b11: begin
                grant_any_s = 1'b1;
                grant_ch_s  = rr_r;
                rr_next_s   = other_ch(rr_r);
            end
            default: begin
                grant_any_s = 1'b0;
            end
        endcase
        if (grant_ch_s == CH_Y) begin
            add_a_s = y_op0_r;
            add_b_s = y_op1_r;
        end else begin
            add_a_s = x_op0_r;
            add_b_s = x_op1_r;
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s};
    end

    // Arbiter pointer, completed-operation counter and ready enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_r       <= CH_X;
            op_count_r <= '0;
            ready_en_r <= 1'b0;
        end else begin
            rr_r       <= rr_next_s;
            ready_en_r <= 1'b1;
            if (grant_any_s) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end else begin
                op_count_r <= op_count_r;
            end
        end
    end

    // X channel: capture at acceptance, result on grant, release on consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_pend_r      <= 1'b0;
            x_op0_r       <= '0;
            x_op1_r       <= '0;
            x_res_r       <= '0;
            x_res_valid_r <= 1'b0;
        end else begin
            if (x_accept_s) begin
                x_op0_r  <= x_sel0_s;
                x_op1_r  <= x_sel1_s;
                x_pend_r <= 1'b1;
            end else if (grant_any_s && grant_ch_s == CH_X) begin
                x_pend_r <= 1'b0;
            end else begin
                x_pend_r <= x_pend_r;
            end
            if (grant_any_s && grant_ch_s == CH_X) begin
                x_res_r       <= sum_s;
                x_res_valid_r <= 1'b1;
            end else if (x_res_valid_r && bus.x_res_ready) begin
                x_res_valid_r <= 1'b0;
            end else begin
                x_res_valid_r <= x_res_valid_r;
            end
        end
    end

    // Y channel: capture at acceptance, result on grant, release on consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_pend_r      <= 1'b0;
            y_op0_r       <= '0;
            y_op1_r       <= '0;
            y_res_r       <= '0;
            y_res_valid_r <= 1'b0;
        end else begin
            if (y_accept_s) begin
                y_op0_r  <= y_sel0_s;
                y_op1_r  <= y_sel1_s;
                y_pend_r <= 1'b1;
            end else if (grant_any_s && grant_ch_s == CH_Y) begin
                y_pend_r <= 1'b0;
            end else begin
                y_pend_r <= y_pend_r;
            end
            if (grant_any_s && grant_ch_s == CH_Y) begin
                y_res_r       <= sum_s;
                y_res_valid_r <= 1'b1;
            end else if (y_res_valid_r && bus.y_res_ready) begin
                y_res_valid_r <= 1'b0;
            end else begin
                y_res_valid_r <= y_res_valid_r;
            end
        end
    end

    assign bus.x_req_ready = x_ready_s;
    assign bus.y_req_ready = y_ready_s;
    assign bus.x_res       = x_res_r;
    assign bus.y_res       = y_res_r;
    assign bus.x_res_valid = x_res_valid_r;
    assign bus.y_res_valid = y_res_valid_r;
    assign bus.op_count    = op_count_r;

endmodule
